// File: rtl/xdma_h2c_read_engine.sv
// H2C read engine: turns user read requests into XDMA descriptor-bypass loads,
// checks returned packet lengths and forwards the stream through a skid buffer.
module xdma_h2c_read_engine #(
    parameter int          DATA_WIDTH      = 256,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [15:0] DSC_CTL         = 16'h0010
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    rdReq_valid,
    output logic                    rdReq_ready,
    input  logic [63:0]             rdReq_addr,
    input  logic [27:0]             rdReq_len,
    input  logic                    h2cDescByp_ready,
    output logic                    h2cDescByp_load,
    output logic [63:0]             h2cDescByp_src_addr,
    output logic [63:0]             h2cDescByp_dst_addr,
    output logic [27:0]             h2cDescByp_len,
    output logic [15:0]             h2cDescByp_ctl,
    input  logic                    h2cStream_tvalid,
    input  logic [DATA_WIDTH-1:0]   h2cStream_tdata,
    input  logic [DATA_WIDTH/8-1:0] h2cStream_tkeep,
    input  logic                    h2cStream_tlast,
    output logic                    h2cStream_tready,
    output logic                    rdResp_tvalid,
    output logic [DATA_WIDTH-1:0]   rdResp_tdata,
    output logic [DATA_WIDTH/8-1:0] rdResp_tkeep,
    output logic                    rdResp_tlast,
    input  logic                    rdResp_tready,
    output logic [4:0]              outstanding,
    output logic                    errLen,
    output logic [15:0]             errCount
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W      = $clog2(MAX_OUTSTANDING);

    typedef enum logic {IDLE, LOAD} issue_state_t;

    issue_state_t        state;
    logic [63:0]         req_addr;
    logic [27:0]         req_len;

    logic [27:0]         len_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [4:0]          fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    logic [27:0]         byte_acc;
    logic [27:0]         acc_total;
    logic                beat_fire;
    logic                tlast_fire;
    logic                pop;
    logic                req_fire;
    logic                zero_len_err;
    logic                len_err;

    logic [DATA_WIDTH-1:0] skid_data [2];
    logic [KEEP_WIDTH-1:0] skid_keep [2];
    logic                  skid_last [2];
    logic                  skid_wr;
    logic                  skid_rd;
    logic [1:0]            skid_count;
    logic [1:0]            skid_next_count;
    logic                  skid_ready;
    logic                  out_fire;

    function automatic logic [27:0] keep_bytes(input logic [KEEP_WIDTH-1:0] keep);
        logic [27:0] n;
        n = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            n = n + {27'd0, keep[i]};
        end
        return n;
    endfunction

    assign fifo_full    = (fifo_count == 5'(MAX_OUTSTANDING));
    assign fifo_empty   = (fifo_count == 5'd0);
    assign rdReq_ready  = (state == IDLE) && !fifo_full;
    assign req_fire     = rdReq_valid && rdReq_ready;
    assign zero_len_err = req_fire && (rdReq_len == 28'd0);

    assign h2cDescByp_load     = (state == LOAD) && h2cDescByp_ready;
    assign h2cDescByp_src_addr = req_addr;
    assign h2cDescByp_len      = req_len;
    assign h2cDescByp_dst_addr = 64'd0;
    assign h2cDescByp_ctl      = DSC_CTL;

    // Zero-length requests are consumed in IDLE and never reach the XDMA.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            req_addr <= 64'd0;
            req_len  <= 28'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire && (rdReq_len != 28'd0)) begin
                        req_addr <= rdReq_addr;
                        req_len  <= rdReq_len;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (h2cDescByp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign beat_fire  = h2cStream_tvalid && h2cStream_tready;
    assign tlast_fire = beat_fire && h2cStream_tlast;
    assign acc_total  = byte_acc + keep_bytes(h2cStream_tkeep);
    assign pop        = tlast_fire && !fifo_empty;
    assign len_err    = tlast_fire && (fifo_empty || (acc_total != len_mem[rd_ptr]));
    assign outstanding = fifo_count;

    always_ff @(posedge CLK) begin
        if (h2cDescByp_load) begin
            len_mem[wr_ptr] <= req_len;
        end
    end

    // A tlast with nothing outstanding is an orphan: flagged but nothing popped.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 5'd0;
            byte_acc   <= 28'd0;
            errLen     <= 1'b0;
            errCount   <= 16'd0;
        end else begin
            if (h2cDescByp_load) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (h2cDescByp_load && !pop) begin
                fifo_count <= fifo_count + 5'd1;
            end else if (pop && !h2cDescByp_load) begin
                fifo_count <= fifo_count - 5'd1;
            end
            if (beat_fire) begin
                byte_acc <= h2cStream_tlast ? 28'd0 : acc_total;
            end
            errLen <= zero_len_err || len_err;
            if ((zero_len_err || len_err) && (errCount != 16'hFFFF)) begin
                errCount <= errCount + 16'd1;
            end
        end
    end

    assign out_fire         = rdResp_tvalid && rdResp_tready;
    assign h2cStream_tready = skid_ready;
    assign rdResp_tvalid    = (skid_count != 2'd0);
    assign rdResp_tdata     = skid_data[skid_rd];
    assign rdResp_tkeep     = skid_keep[skid_rd];
    assign rdResp_tlast     = skid_last[skid_rd];

    always_comb begin
        skid_next_count = skid_count;
        if (beat_fire && !out_fire) begin
            skid_next_count = skid_count + 2'd1;
        end else if (out_fire && !beat_fire) begin
            skid_next_count = skid_count - 2'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (beat_fire) begin
            skid_data[skid_wr] <= h2cStream_tdata;
            skid_keep[skid_wr] <= h2cStream_tkeep;
            skid_last[skid_wr] <= h2cStream_tlast;
        end
    end

    // Ready is a flop so the user's backpressure never reaches the XDMA combinationally.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            skid_wr    <= 1'b0;
            skid_rd    <= 1'b0;
            skid_count <= 2'd0;
            skid_ready <= 1'b1;
        end else begin
            if (beat_fire) begin
                skid_wr <= ~skid_wr;
            end
            if (out_fire) begin
                skid_rd <= ~skid_rd;
            end
            skid_count <= skid_next_count;
            skid_ready <= (skid_next_count != 2'd2);
        end
    end

endmodule

// File: tb/tb_xdma_h2c_read_engine.sv
// Scoreboard bench for xdma_h2c_read_engine: descriptors, stream data order,
// length checking, orphan beats, backpressure and mid-packet reset.
module tb_xdma_h2c_read_engine;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [27:0] len;
    } desc_t;

    logic         CLK;
    logic         RST_N;
    logic         rdReq_valid;
    logic         rdReq_ready;
    logic [63:0]  rdReq_addr;
    logic [27:0]  rdReq_len;
    logic         h2cDescByp_ready;
    logic         h2cDescByp_load;
    logic [63:0]  h2cDescByp_src_addr;
    logic [63:0]  h2cDescByp_dst_addr;
    logic [27:0]  h2cDescByp_len;
    logic [15:0]  h2cDescByp_ctl;
    logic         h2cStream_tvalid;
    logic [255:0] h2cStream_tdata;
    logic [31:0]  h2cStream_tkeep;
    logic         h2cStream_tlast;
    logic         h2cStream_tready;
    logic         rdResp_tvalid;
    logic [255:0] rdResp_tdata;
    logic [31:0]  rdResp_tkeep;
    logic         rdResp_tlast;
    logic         rdResp_tready = 1'b1;
    logic [4:0]   outstanding;
    logic         errLen;
    logic [15:0]  errCount;

    int checkCount = 0;
    int passCount  = 0;

    beat_t       expBeats[$];
    desc_t       expDescQ[$];
    logic [27:0] modelLenQ[$];
    logic [27:0] modelAcc = '0;
    logic        expErr = 1'b0;
    logic [15:0] modelErrCount = '0;
    logic        prevLoad = 1'b0;
    logic        randomReady = 1'b0;
    logic        holdOff = 1'b0;

    xdma_h2c_read_engine #(
        .DATA_WIDTH(256),
        .MAX_OUTSTANDING(4),
        .DSC_CTL(16'h0010)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .rdReq_valid(rdReq_valid),
        .rdReq_ready(rdReq_ready),
        .rdReq_addr(rdReq_addr),
        .rdReq_len(rdReq_len),
        .h2cDescByp_ready(h2cDescByp_ready),
        .h2cDescByp_load(h2cDescByp_load),
        .h2cDescByp_src_addr(h2cDescByp_src_addr),
        .h2cDescByp_dst_addr(h2cDescByp_dst_addr),
        .h2cDescByp_len(h2cDescByp_len),
        .h2cDescByp_ctl(h2cDescByp_ctl),
        .h2cStream_tvalid(h2cStream_tvalid),
        .h2cStream_tdata(h2cStream_tdata),
        .h2cStream_tkeep(h2cStream_tkeep),
        .h2cStream_tlast(h2cStream_tlast),
        .h2cStream_tready(h2cStream_tready),
        .rdResp_tvalid(rdResp_tvalid),
        .rdResp_tdata(rdResp_tdata),
        .rdResp_tkeep(rdResp_tkeep),
        .rdResp_tlast(rdResp_tlast),
        .rdResp_tready(rdResp_tready),
        .outstanding(outstanding),
        .errLen(errLen),
        .errCount(errCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // User-side backpressure: held off, random, or always ready.
    always @(posedge CLK) begin
        #1;
        if (holdOff) rdResp_tready = 1'b0;
        else if (randomReady) rdResp_tready = 1'($urandom_range(0, 1));
        else rdResp_tready = 1'b1;
    end

    // Monitor: checks registered outputs, then predicts the effect of the coming edge.
    always @(negedge CLK) begin
        logic        nextErr;
        logic [27:0] acc;
        logic [27:0] headLen;
        desc_t       d;
        beat_t       b;
        if (!RST_N) begin
            expBeats.delete();
            expDescQ.delete();
            modelLenQ.delete();
            modelAcc      = '0;
            expErr        = 1'b0;
            modelErrCount = '0;
            prevLoad      = 1'b0;
        end else begin
            checkOutput("errLen", 256'(errLen), 256'(expErr));
            checkOutput("errCount", 256'(errCount), 256'(modelErrCount));
            checkOutput("outstanding", 256'(outstanding), 256'(modelLenQ.size()));
            checkOutput("loadTwice", 256'(h2cDescByp_load && prevLoad), 256'(0));
            if (!h2cDescByp_ready) checkOutput("loadGate", 256'(h2cDescByp_load), 256'(0));
            prevLoad = h2cDescByp_load;
            nextErr  = 1'b0;

            if (h2cStream_tvalid && h2cStream_tready) begin
                acc = modelAcc + 28'($countones(h2cStream_tkeep));
                if (h2cStream_tlast) begin
                    if (modelLenQ.size() == 0) begin
                        nextErr = 1'b1;
                    end else begin
                        headLen = modelLenQ.pop_front();
                        if (acc != headLen) nextErr = 1'b1;
                    end
                    modelAcc = '0;
                end else begin
                    modelAcc = acc;
                end
            end

            if (h2cDescByp_load) begin
                if (expDescQ.size() == 0) begin
                    checkOutput("unexpectedLoad", 256'(1), 256'(0));
                end else begin
                    d = expDescQ.pop_front();
                    checkOutput("descSrc", 256'(h2cDescByp_src_addr), 256'(d.addr));
                    checkOutput("descLen", 256'(h2cDescByp_len), 256'(d.len));
                    checkOutput("descCtl", 256'(h2cDescByp_ctl), 256'(16'h0010));
                    checkOutput("descDst", 256'(h2cDescByp_dst_addr), 256'(0));
                    modelLenQ.push_back(d.len);
                end
            end

            if (rdReq_valid && rdReq_ready) begin
                if (rdReq_len == 28'd0) nextErr = 1'b1;
                else expDescQ.push_back('{addr: rdReq_addr, len: rdReq_len});
            end

            if (rdResp_tvalid && rdResp_tready) begin
                if (expBeats.size() == 0) begin
                    checkOutput("unexpectedBeat", 256'(1), 256'(0));
                end else begin
                    b = expBeats.pop_front();
                    checkOutput("respData", rdResp_tdata, b.data);
                    checkOutput("respKeep", 256'(rdResp_tkeep), 256'(b.keep));
                    checkOutput("respLast", 256'(rdResp_tlast), 256'(b.last));
                end
            end

            expErr = nextErr;
            if (nextErr && modelErrCount != 16'hFFFF) modelErrCount = modelErrCount + 16'd1;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic applyRequest(input logic [63:0] addr, input logic [27:0] len);
        bit accepted = 0;
        rdReq_addr  = addr;
        rdReq_len   = len;
        rdReq_valid = 1'b1;
        for (int c = 0; c < 300 && !accepted; c++) begin
            @(negedge CLK);
            if (rdReq_ready && RST_N) accepted = 1;
        end
        @(posedge CLK);
        #1;
        rdReq_valid = 1'b0;
        if (!accepted) checkOutput("reqTimeout", 256'(0), 256'(1));
    endtask

    task automatic applyBeat(input logic [255:0] data, input logic [31:0] keep, input logic last);
        bit accepted = 0;
        h2cStream_tdata  = data;
        h2cStream_tkeep  = keep;
        h2cStream_tlast  = last;
        h2cStream_tvalid = 1'b1;
        for (int c = 0; c < 300 && !accepted; c++) begin
            @(negedge CLK);
            if (h2cStream_tready && RST_N) begin
                expBeats.push_back('{data: data, keep: keep, last: last});
                accepted = 1;
            end
        end
        @(posedge CLK);
        #1;
        h2cStream_tvalid = 1'b0;
        if (!accepted) checkOutput("beatTimeout", 256'(0), 256'(1));
    endtask

    // Sends one packet of the given byte count: full beats, then a partial last beat.
    task automatic applyStimulus(input int bytes);
        int nBeats = (bytes + 31) / 32;
        for (int i = 0; i < nBeats; i++) begin
            logic [255:0] data;
            logic [31:0]  keep;
            int           rem = bytes - i * 32;
            for (int w = 0; w < 8; w++) data[w*32 +: 32] = $urandom();
            keep = (rem >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << rem) - 64'd1);
            applyBeat(data, keep, (i == nBeats - 1));
        end
    endtask

    task automatic waitDrain();
        bit drained = 0;
        for (int c = 0; c < 300 && !drained; c++) begin
            @(negedge CLK);
            if (expBeats.size() == 0 && modelLenQ.size() == 0) drained = 1;
        end
        checkOutput("drain", 256'(expBeats.size() + modelLenQ.size()), 256'(0));
        waitCycles(2);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "ReqReady"}, 256'(rdReq_ready), 256'(1));
        checkOutput({tag, "Load"}, 256'(h2cDescByp_load), 256'(0));
        checkOutput({tag, "Src"}, 256'(h2cDescByp_src_addr), 256'(0));
        checkOutput({tag, "Len"}, 256'(h2cDescByp_len), 256'(0));
        checkOutput({tag, "Dst"}, 256'(h2cDescByp_dst_addr), 256'(0));
        checkOutput({tag, "Ctl"}, 256'(h2cDescByp_ctl), 256'(16'h0010));
        checkOutput({tag, "Tready"}, 256'(h2cStream_tready), 256'(1));
        checkOutput({tag, "Tvalid"}, 256'(rdResp_tvalid), 256'(0));
        checkOutput({tag, "Outst"}, 256'(outstanding), 256'(0));
        checkOutput({tag, "ErrLen"}, 256'(errLen), 256'(0));
        checkOutput({tag, "ErrCnt"}, 256'(errCount), 256'(0));
    endtask

    initial begin
        int lens[5] = '{32, 64, 40, 96, 32};
        RST_N            = 1'b0;
        rdReq_valid      = 1'b0;
        rdReq_addr       = '0;
        rdReq_len        = '0;
        h2cDescByp_ready = 1'b1;
        h2cStream_tvalid = 1'b0;
        h2cStream_tdata  = '0;
        h2cStream_tkeep  = '0;
        h2cStream_tlast  = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkResetValues("rst");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        waitCycles(2);

        $display("[TB] single read");
        applyRequest(64'h1000, 28'd64);
        @(negedge CLK);
        checkOutput("t1Load", 256'(h2cDescByp_load), 256'(1));
        checkOutput("t1Src", 256'(h2cDescByp_src_addr), 256'(64'h1000));
        checkOutput("t1Len", 256'(h2cDescByp_len), 256'(64));
        checkOutput("t1Outst0", 256'(outstanding), 256'(0));
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("t1Outst1", 256'(outstanding), 256'(1));
        @(posedge CLK);
        #1;
        applyStimulus(64);
        waitDrain();
        checkOutput("t1OutstEnd", 256'(outstanding), 256'(0));
        checkOutput("t1ErrCnt", 256'(errCount), 256'(0));

        $display("[TB] partial beat with descriptor backpressure");
        h2cDescByp_ready = 1'b0;
        applyRequest(64'h2000, 28'd40);
        waitCycles(3);
        @(negedge CLK);
        checkOutput("t2LoadHeld", 256'(h2cDescByp_load), 256'(0));
        @(posedge CLK);
        #1;
        h2cDescByp_ready = 1'b1;
        waitCycles(2);
        applyStimulus(40);
        waitDrain();
        checkOutput("t2ErrCnt", 256'(errCount), 256'(0));

        $display("[TB] mismatch and zero length");
        applyRequest(64'h3000, 28'd64);
        waitCycles(2);
        applyStimulus(32);
        waitDrain();
        @(negedge CLK);
        checkOutput("t3ErrCnt1", 256'(errCount), 256'(1));
        @(posedge CLK);
        #1;
        applyRequest(64'h3100, 28'd0);
        waitCycles(3);
        @(negedge CLK);
        checkOutput("t3ErrCnt2", 256'(errCount), 256'(2));
        checkOutput("t3Outst", 256'(outstanding), 256'(0));
        @(posedge CLK);
        #1;

        $display("[TB] full FIFO and random backpressure");
        randomReady = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) applyRequest(64'h4000 + 64'(i) * 64'h100, 28'(lens[i]));
            end
            begin
                waitCycles(20);
                @(negedge CLK);
                checkOutput("t4ReqReadyLow", 256'(rdReq_ready), 256'(0));
                checkOutput("t4OutstMax", 256'(outstanding), 256'(4));
                @(posedge CLK);
                #1;
                for (int i = 0; i < 4; i++) applyStimulus(lens[i]);
            end
        join
        waitCycles(3);
        applyStimulus(lens[4]);
        waitDrain();
        randomReady = 1'b0;
        checkOutput("t4ErrCnt", 256'(errCount), 256'(2));

        $display("[TB] orphan beat");
        applyStimulus(32);
        waitDrain();
        checkOutput("t5ErrCnt", 256'(errCount), 256'(3));

        $display("[TB] reset mid-packet");
        applyRequest(64'h6000, 28'd96);
        waitCycles(2);
        holdOff = 1'b1;
        waitCycles(1);
        applyBeat({8{32'hA5A5_0001}}, 32'hFFFF_FFFF, 1'b0);
        applyBeat({8{32'hA5A5_0002}}, 32'hFFFF_FFFF, 1'b0);
        RST_N = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checkResetValues("midRst");
        holdOff = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        waitCycles(2);
        applyRequest(64'h7000, 28'd32);
        waitCycles(2);
        applyStimulus(32);
        waitDrain();
        checkOutput("t6ErrCnt", 256'(errCount), 256'(0));
        checkOutput("t6Outst", 256'(outstanding), 256'(0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
